// File: rtl/jtkcpu_brseq.sv
// rtl/jtkcpu_brseq.sv - KONAMI-1 relative branch / subroutine call sequencer
// Fetches the branch offset, pushes the return address for BSR/LBSR, then issues one PC/S update.

package jtkcpu_brseq_pkg;
    localparam logic [7:0] OP_BSR  = 8'h8D;
    localparam logic [7:0] OP_LBSR = 8'h8E;

    // Short branches live at 0x60-0x6F, long branches at 0x70-0x7F.
    function automatic logic is_branch(input logic [7:0] op);
        return op[7:5] == 3'b011;
    endfunction

    function automatic logic is_long(input logic [7:0] op);
        return (op[7:4] == 4'h7) || (op == OP_LBSR);
    endfunction

    function automatic logic is_sub(input logic [7:0] op);
        return (op == OP_BSR) || (op == OP_LBSR);
    endfunction
endpackage

module jtkcpu_branch (
    input  logic [7:0] op,
    input  logic [7:0] cc,
    output logic       taken
);
    import jtkcpu_brseq_pkg::*;

    logic c, v, z, n, base;
    logic unused_cc;

    assign c = cc[0];
    assign v = cc[1];
    assign z = cc[2];
    assign n = cc[3];
    assign unused_cc = ^cc[7:4];

    // Conditions come in complementary pairs: even code is the base test, odd code inverts it.
    always_comb begin
        case (op[3:1])
            3'd0:    base = 1'b1;
            3'd1:    base = !(c || z);
            3'd2:    base = !c;
            3'd3:    base = !z;
            3'd4:    base = !v;
            3'd5:    base = !n;
            3'd6:    base = (n == v);
            default: base = !z && (n == v);
        endcase
        if (is_sub(op)) begin
            taken = 1'b1;
        end else if (is_branch(op)) begin
            taken = base ^ op[0];
        end else begin
            taken = 1'b0;
        end
    end
endmodule

module jtkcpu_brseq (
    input  logic        rst_n,
    input  logic        clk,
    input  logic        cen,
    input  logic        start,
    input  logic [7:0]  op,
    input  logic [7:0]  cc,
    input  logic [15:0] pc,
    input  logic [15:0] s,
    input  logic [7:0]  bus_din,
    input  logic        bus_ack,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_dout,
    output logic        bus_rd,
    output logic        bus_wr,
    output logic        busy,
    output logic        done,
    output logic        pc_we,
    output logic [15:0] pc_next,
    output logic        s_we,
    output logic [15:0] s_next,
    output logic        taken
);
    import jtkcpu_brseq_pkg::*;

    typedef enum logic [2:0] {IDLE, RD_HI, RD_LO, WR_LO, WR_HI, DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  op_q, op_d, cc_q, cc_d;
    logic [15:0] pc_q, pc_d, s_q, s_d, off_q, off_d;
    logic        long_l, sub_l, cond;
    logic [15:0] ret;

    assign long_l = is_long(op_q);
    assign sub_l  = is_sub(op_q);
    assign ret    = pc_q + 16'd1 + {15'd0, long_l};

    jtkcpu_branch u_branch (
        .op    (op_q),
        .cc    (cc_q),
        .taken (cond)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= 8'd0;
            cc_q    <= 8'd0;
            pc_q    <= 16'd0;
            s_q     <= 16'd0;
            off_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cc_q    <= cc_d;
            pc_q    <= pc_d;
            s_q     <= s_d;
            off_q   <= off_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cc_d    = cc_q;
        pc_d    = pc_q;
        s_d     = s_q;
        off_d   = off_q;
        if (cen) begin
            case (state_q)
                IDLE: if (start) begin
                    op_d    = op;
                    cc_d    = cc;
                    pc_d    = pc;
                    s_d     = s;
                    state_d = is_long(op) ? RD_HI : RD_LO;
                end
                RD_HI: if (bus_ack) begin
                    off_d[15:8] = bus_din;
                    state_d     = RD_LO;
                end
                RD_LO: if (bus_ack) begin
                    off_d[7:0] = bus_din;
                    if (!long_l) off_d[15:8] = {8{bus_din[7]}};
                    state_d = sub_l ? WR_LO : DONE;
                end
                WR_LO: if (bus_ack) state_d = WR_HI;
                WR_HI: if (bus_ack) state_d = DONE;
                DONE:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bus_addr = 16'd0;
        bus_dout = 8'd0;
        bus_rd   = 1'b0;
        bus_wr   = 1'b0;
        done     = 1'b0;
        pc_we    = 1'b0;
        s_we     = 1'b0;
        taken    = 1'b0;
        pc_next  = 16'd0;
        s_next   = 16'd0;
        busy     = (state_q != IDLE);
        case (state_q)
            RD_HI: begin
                bus_rd   = 1'b1;
                bus_addr = pc_q;
            end
            RD_LO: begin
                bus_rd   = 1'b1;
                bus_addr = pc_q + {15'd0, long_l};
            end
            WR_LO: begin
                bus_wr   = 1'b1;
                bus_addr = s_q - 16'd1;
                bus_dout = ret[7:0];
            end
            WR_HI: begin
                bus_wr   = 1'b1;
                bus_addr = s_q - 16'd2;
                bus_dout = ret[15:8];
            end
            DONE: begin
                done    = 1'b1;
                pc_we   = 1'b1;
                s_we    = sub_l;
                taken   = cond;
                pc_next = cond ? ret + off_q : ret;
                s_next  = s_q - 16'd2;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_jtkcpu_brseq.sv
// tb/tb_jtkcpu_brseq.sv - randomized self-checking bench for jtkcpu_brseq
`timescale 1ns/1ps
module tb_jtkcpu_brseq;
    localparam logic [7:0] BSR  = 8'h8D;
    localparam logic [7:0] LBSR = 8'h8E;

    logic        clk = 1'b0, rst_n = 1'b0, cen = 1'b1, start = 1'b0, bus_ack = 1'b1;
    logic [7:0]  op = 8'd0, cc = 8'd0, bus_din = 8'd0;
    logic [15:0] pc = 16'd0, s = 16'd0;
    logic [15:0] bus_addr, pc_next, s_next;
    logic [7:0]  bus_dout;
    logic        bus_rd, bus_wr, busy, done, pc_we, s_we, taken;

    int n_pass = 0, n_chk = 0, cyc = 0, start_cyc = 0, stall = 0, wcnt = 0;

    // expected bus accesses in order: kind (1 = write), address, data (read data to supply / write data)
    logic        q_wr[$];
    logic [15:0] q_addr[$];
    logic [7:0]  q_data[$];
    logic [15:0] e_pc_next, e_s_next, got_pc_next, got_s_next;
    logic        e_taken, e_s_we, got_taken, got_s_we;
    int          e_lat;
    logic        done_seen = 1'b0, prev_done = 1'b0, pop_pending = 1'b0;

    jtkcpu_brseq dut (
        .rst_n(rst_n), .clk(clk), .cen(cen), .start(start), .op(op), .cc(cc), .pc(pc), .s(s),
        .bus_din(bus_din), .bus_ack(bus_ack), .bus_addr(bus_addr), .bus_dout(bus_dout),
        .bus_rd(bus_rd), .bus_wr(bus_wr), .busy(busy), .done(done), .pc_we(pc_we),
        .pc_next(pc_next), .s_we(s_we), .s_next(s_next), .taken(taken)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    function automatic logic cond_of(input logic [3:0] code, input logic [7:0] f);
        logic cf, vf, zf, nf, r;
        cf = f[0]; vf = f[1]; zf = f[2]; nf = f[3];
        case (code)
            4'h0: r = 1'b1;              4'h1: r = 1'b0;
            4'h2: r = !cf && !zf;        4'h3: r = cf || zf;
            4'h4: r = !cf;               4'h5: r = cf;
            4'h6: r = !zf;               4'h7: r = zf;
            4'h8: r = !vf;               4'h9: r = vf;
            4'hA: r = !nf;               4'hB: r = nf;
            4'hC: r = (nf == vf);        4'hD: r = (nf != vf);
            4'hE: r = !zf && (nf == vf); default: r = zf || (nf != vf);
        endcase
        return r;
    endfunction

    task automatic push(input logic w, input logic [15:0] a, input logic [7:0] d);
        q_wr.push_back(w); q_addr.push_back(a); q_data.push_back(d);
    endtask

    task automatic model(input logic [7:0] o, input logic [7:0] f, input logic [15:0] p,
                         input logic [15:0] sp, input logic [7:0] b0, input logic [7:0] b1);
        logic lng, sub, br;
        logic [15:0] off, ret, a;
        sub = (o == BSR) || (o == LBSR);
        lng = (o >= 8'h70 && o <= 8'h7F) || (o == LBSR);
        br  = (o >= 8'h60 && o <= 8'h7F);
        q_wr.delete(); q_addr.delete(); q_data.delete();
        push(1'b0, p, b0);
        if (lng) begin
            a = p + 16'd1;
            push(1'b0, a, b1);
            off = {b0, b1};
            ret = p + 16'd2;
        end else begin
            off = {{8{b0[7]}}, b0};
            ret = p + 16'd1;
        end
        e_taken   = sub ? 1'b1 : (br ? cond_of(o[3:0], f) : 1'b0);
        e_pc_next = e_taken ? ret + off : ret;
        e_s_next  = sp - 16'd2;
        e_s_we    = sub;
        e_lat     = 2 + int'(lng) + 2 * int'(sub);
        if (sub) begin
            a = sp - 16'd1;
            push(1'b1, a, ret[7:0]);
            a = sp - 16'd2;
            push(1'b1, a, ret[15:8]);
        end
    endtask

    // compare process: checks every cycle, then drives the handshake for the coming edge
    always @(negedge clk) begin
        if (!rst_n) begin
            pop_pending = 1'b0;
            prev_done   = 1'b0;
            wcnt        = 0;
        end else begin
            if (pop_pending && q_wr.size() > 0) begin
                void'(q_wr.pop_front()); void'(q_addr.pop_front()); void'(q_data.pop_front());
                wcnt = 0;
            end
            pop_pending = 1'b0;
            chk("rd_wr_exclusive", {31'd0, bus_rd & bus_wr}, 32'd0);
            chk("pc_we_matches_done", {31'd0, pc_we}, {31'd0, done});
            if (!busy || done) chk("no_req_idle_done", {30'd0, bus_rd, bus_wr}, 32'd0);
            if (bus_rd || bus_wr) begin
                if (q_wr.size() == 0) chk("unexpected_req", 32'd1, 32'd0);
                else begin
                    chk("req_kind", {31'd0, bus_wr}, {31'd0, q_wr[0]});
                    chk("req_addr", {16'd0, bus_addr}, {16'd0, q_addr[0]});
                    if (bus_wr) chk("wr_data", {24'd0, bus_dout}, {24'd0, q_data[0]});
                end
            end
            if (done && !prev_done) begin
                chk("pc_next", {16'd0, pc_next}, {16'd0, e_pc_next});
                chk("s_next", {16'd0, s_next}, {16'd0, e_s_next});
                chk("s_we", {31'd0, s_we}, {31'd0, e_s_we});
                chk("taken", {31'd0, taken}, {31'd0, e_taken});
                chk("accesses_left", 32'(q_wr.size()), 32'd0);
                if (stall == 0) chk("latency", 32'(cyc - start_cyc), 32'(e_lat));
                got_pc_next = pc_next; got_s_next = s_next;
                got_taken   = taken;   got_s_we   = s_we;
                done_seen   = 1'b1;
            end
            prev_done = done;
            if (stall == 1) begin
                cen     = ($urandom_range(0, 1) == 1);
                bus_ack = ($urandom_range(0, 3) == 0);
            end else if (stall == 2) begin
                cen     = ~cen;
                bus_ack = (wcnt >= 3);
            end else begin
                cen     = 1'b1;
                bus_ack = 1'b1;
            end
            bus_din = (q_wr.size() > 0 && !q_wr[0]) ? q_data[0] : 8'($urandom);
            if (bus_rd || bus_wr) begin
                wcnt++;
                if (cen && bus_ack) pop_pending = 1'b1;
            end
        end
    end

    task automatic run(input logic [7:0] o, input logic [7:0] f, input logic [15:0] p,
                       input logic [15:0] sp, input logic [7:0] b0, input logic [7:0] b1,
                       input int mode, input logic junk);
        int t;
        stall = mode;
        @(negedge clk);
        model(o, f, p, sp, b0, b1);
        done_seen = 1'b0;
        op = o; cc = f; pc = p; s = sp; start = 1'b1;
        start_cyc = cyc;
        t = 0;
        do begin @(negedge clk); t++; end while (!busy && t < 100);
        if (!busy) chk("start_accept_timeout", 32'd0, 32'd1);
        if (junk) begin
            op = LBSR; cc = 8'($urandom); pc = 16'($urandom); s = 16'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        t = 0;
        while (!done_seen && t < 500) begin @(negedge clk); t++; end
        if (!done_seen) chk("done_timeout", 32'd0, 32'd1);
        t = 0;
        while (busy && t < 50) begin @(negedge clk); t++; end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_rd"}, {31'd0, bus_rd}, 32'd0);
        chk({tag, "_wr"}, {31'd0, bus_wr}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_flags"}, {29'd0, pc_we, s_we, taken}, 32'd0);
        chk({tag, "_addr_dout"}, {8'd0, bus_addr, bus_dout}, 32'd0);
        chk({tag, "_pcs_next"}, {pc_next, s_next}, 32'd0);
    endtask

    initial begin
        int t;
        logic [7:0] o, f, b0, b1;
        logic [15:0] p, sp;
        #12;
        chk_zero_outputs("reset");
        @(negedge clk); rst_n = 1'b1;

        run(8'h67, 8'h04, 16'h1001, 16'h0100, 8'hFE, 8'h00, 0, 1'b0);
        chk("beq_pc_next", {16'd0, got_pc_next}, 32'h1000);
        chk("beq_taken_swe", {30'd0, got_taken, got_s_we}, 32'd2);

        run(8'h66, 8'h04, 16'h2000, 16'h0100, 8'h10, 8'h00, 0, 1'b0);
        chk("bne_pc_next", {16'd0, got_pc_next}, 32'h2001);
        chk("bne_taken", {31'd0, got_taken}, 32'd0);

        run(8'h70, 8'h00, 16'hFFF0, 16'h0100, 8'h00, 8'h20, 0, 1'b0);
        chk("lbra_pc_next", {16'd0, got_pc_next}, 32'h0012);

        run(LBSR, 8'h00, 16'h4001, 16'h8000, 8'h01, 8'h00, 0, 1'b0);
        chk("lbsr_pc_next", {16'd0, got_pc_next}, 32'h4103);
        chk("lbsr_s_next", {16'd0, got_s_next}, 32'h7FFE);
        chk("lbsr_s_we", {31'd0, got_s_we}, 32'd1);

        run(BSR, 8'h00, 16'h3000, 16'h1234, 8'h80, 8'h00, 0, 1'b0);
        chk("bsr_pc_next", {16'd0, got_pc_next}, 32'h2F81);
        run(BSR, 8'h00, 16'h3000, 16'h1234, 8'h80, 8'h00, 2, 1'b1);
        chk("bsr_stall_pc_next", {16'd0, got_pc_next}, 32'h2F81);
        chk("bsr_stall_s_next", {16'd0, got_s_next}, 32'h1232);

        // asynchronous reset in the middle of the first stack write
        stall = 0;
        @(negedge clk);
        model(LBSR, 8'h00, 16'h4001, 16'h8000, 8'h01, 8'h00);
        op = LBSR; cc = 8'h00; pc = 16'h4001; s = 16'h8000; start = 1'b1;
        @(negedge clk); start = 1'b0;
        t = 0;
        while (!bus_wr && t < 20) begin @(negedge clk); t++; end
        chk("reached_wr_lo", {16'd0, bus_addr}, 32'h7FFF);
        #2 rst_n = 1'b0;
        #1 chk_zero_outputs("async_reset");
        q_wr.delete(); q_addr.delete(); q_data.delete();
        @(negedge clk); rst_n = 1'b1;
        run(8'h67, 8'h00, 16'h1001, 16'h0100, 8'hFE, 8'h00, 0, 1'b0);
        chk("after_reset_pc_next", {16'd0, got_pc_next}, 32'h1002);

        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: o = 8'h60 + 8'($urandom_range(0, 31));
                6: o = BSR;
                7: o = LBSR;
                default: o = 8'($urandom);
            endcase
            f  = 8'($urandom);
            p  = ($urandom_range(0, 4) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3)) : 16'($urandom);
            sp = ($urandom_range(0, 4) == 0) ? 16'($urandom_range(0, 2)) : 16'($urandom);
            b0 = 8'($urandom);
            b1 = 8'($urandom);
            run(o, f, p, sp, b0, b1, int'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/jtkcpu_brseq.md
# jtkcpu_brseq

Branch sequencer for the KONAMI-1 core. It accepts a relative-branch opcode from the instruction decoder and fetches the 8- or 16-bit offset from the bus. For BSR/LBSR it also pushes the return address on the S stack. It then issues one PC update (and an S update for subroutine calls). Branch conditions are evaluated by an internal jtkcpu_branch instance on the CC value latched at start. The block sits between the decoder and the bus/register file, and owns the bus for the duration of the branch.

## Interface
Parameters: none.
- rst_n  in  1  asynchronous reset, active low
- clk  in  1  clock
- cen  in  1  clock enable; all state changes occur only on cycles with cen=1
- start  in  1  begin branch; sampled only in IDLE with cen=1
- op  in  8  opcode, latched at start; short/long and sub-call classification use the jtkcpu.inc constants
- cc  in  8  condition codes, latched at start
- pc  in  16  address of the first offset byte, latched at start
- s  in  16  stack pointer, latched at start
- bus_din  in  8  read data, valid with bus_ack
- bus_ack  in  1  completes the current read/write
- bus_addr  out  16  bus address
- bus_dout  out  8  write data
- bus_rd  out  1  read request
- bus_wr  out  1  write request
- busy  out  1  state != IDLE
- done  out  1  one-cen pulse in DONE
- pc_we  out  1  high in DONE; PC must load pc_next
- pc_next  out  16  new PC
- s_we  out  1  high in DONE for BSR/LBSR only
- s_next  out  16  new S (s-2)
- taken  out  1  condition result, valid in DONE

## Operation
- Classification: long = any LBxx/LBSR opcode; sub = BSR or LBSR. Any other opcode is treated as a short, not-taken branch.
- States: IDLE, RD_HI, RD_LO, WR_LO, WR_HI, DONE.
- From IDLE on start, go to RD_HI if long, otherwise RD_LO.
- RD_HI: bus_addr=pc, bus_rd=1. On ack, off[15:8]=bus_din, then go to RD_LO.
- RD_LO: bus_addr = pc+long, bus_rd=1.
  - On ack, off[7:0]=bus_din; for a short branch, off[15:8] is the sign extension of bus_din[7].
  - ret = pc+1+long.
  - Next state is WR_LO if sub, otherwise DONE.
- WR_LO: bus_addr=s-1, bus_dout=ret[7:0], bus_wr=1. On ack, go to WR_HI.
- WR_HI: bus_addr=s-2, bus_dout=ret[15:8], bus_wr=1. On ack, go to DONE.
- DONE: lasts one cen cycle, then returns to IDLE.
  - taken = jtkcpu_branch(op_l, cc_l).
  - pc_next = taken ? ret+off : ret.
  - s_next = s-2.
- Offset bytes are fetched even when the branch is not taken (BRN and LBRN consume their operand bytes).
- All address arithmetic is modulo 2^16, so wrap-around is silent.
- bus_rd and bus_wr are mutually exclusive and never both high. Both are low in IDLE and DONE.
- bus_addr and bus_dout hold stable while a request is pending.
- A start pulse while busy is ignored.
- An ack arriving when no request is pending is ignored.

## Timing
- Reset (asynchronous, any state) forces IDLE, with outputs:
  - bus_rd=bus_wr=0
  - busy=done=pc_we=s_we=taken=0
  - bus_addr=0, bus_dout=0, pc_next=0, s_next=0
- A reset during a bus cycle drops the request immediately.
- Outputs are registered or decoded from state only. There is no combinational path from start or bus_ack to any output.
- A request is asserted in the first cen cycle after the state is entered. It completes on the cen cycle where bus_ack=1. With bus_ack=1 and cen=1 continuously, each bus state lasts exactly 1 cycle.
- Latency from the start cycle to done (ack always high, cen=1): short branch 2 cycles, long branch 3, BSR 4, LBSR 5.
- Each cycle with bus_ack=0 or cen=0 adds one cycle and holds the current state.
- Throughput: a new start is accepted in the cycle after DONE (IDLE).

## Test plan
- BEQ with cc Z=1, pc=0x1001, byte 0xFE -> one read at 0x1001; done 2 cycles after start; taken=1, pc_next=0x1000, pc_we=1, s_we=0.
- BNE with cc Z=1, pc=0x2000, byte 0x10 -> taken=0, pc_next=0x2001; offset byte still read.
- LBRA with pc=0xFFF0, bytes 0x00,0x20 -> reads at 0xFFF0 then 0xFFF1; ret=0xFFF2; pc_next=0x0012 (wrap).
- LBSR with pc=0x4001, s=0x8000, bytes 0x01,0x00 -> write 0x03@0x7FFF, then 0x40@0x7FFE; pc_next=0x4103, s_next=0x7FFE, s_we=1; done 5 cycles after start.
- BSR with bus_ack low for 3 cycles on each access and cen toggling every other cycle -> request and address stay stable until ack with cen. Results are identical to the no-stall case. A start pulse while busy has no effect.
- Reset asserted during WR_LO of an LBSR -> bus_wr drops asynchronously, all outputs go to 0, the block returns to IDLE, and a new start after reset runs normally.
